// File: rtl/mem_stage.sv
// RV64 memory-access stage: one bus transaction per load/store, load-data
// alignment and extension, and a held writeback record for the register file.
module mem_stage #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic [4:0]        in_rd,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [XLEN-1:0]   in_alu_result,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [7:0]        mem_req_wstrb,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_resp_data,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_we,
  output logic              wb_exc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  typedef struct packed {
    logic       is_load;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [2:0] off;
  } op_t;

  state_t state;
  op_t    op;

  logic            in_is_load, in_is_store, in_misal;
  logic [2:0]      in_mask;
  logic [7:0]      in_strb;
  logic [XLEN-1:0] in_wdata;
  logic [XLEN-1:0] rsh, ld_val;

  assign in_ready    = (state == IDLE);
  assign in_is_load  = (in_kind == 2'd1);
  assign in_is_store = (in_kind == 2'd2);

  // Size decode: low-address mask for alignment, base byte-enable pattern
  always_comb begin
    in_mask = 3'b000;
    in_strb = 8'h01;
    case (in_funct3[1:0])
      2'd0: begin in_mask = 3'b000; in_strb = 8'h01; end
      2'd1: begin in_mask = 3'b001; in_strb = 8'h03; end
      2'd2: begin in_mask = 3'b011; in_strb = 8'h0F; end
      default: begin in_mask = 3'b111; in_strb = 8'hFF; end
    endcase
  end

  assign in_misal = |(in_addr[2:0] & in_mask);
  assign in_wdata = in_store_data << {in_addr[2:0], 3'b000};

  // Load data: move addressed bytes to bit 0, then truncate and extend
  assign rsh = mem_resp_data >> {op.off, 3'b000};
  always_comb begin
    ld_val = rsh;
    case (op.funct3[1:0])
      2'd0: ld_val = op.funct3[2] ? {{(XLEN-8){1'b0}}, rsh[7:0]}
                                  : {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      2'd1: ld_val = op.funct3[2] ? {{(XLEN-16){1'b0}}, rsh[15:0]}
                                  : {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      2'd2: ld_val = op.funct3[2] ? {{(XLEN-32){1'b0}}, rsh[31:0]}
                                  : {{(XLEN-32){rsh[31]}}, rsh[31:0]};
      default: ld_val = rsh;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      op            <= '0;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_we    <= 1'b0;
      mem_req_wdata <= '0;
      mem_req_wstrb <= 8'h00;
      wb_valid      <= 1'b0;
      wb_rd         <= 5'd0;
      wb_data       <= '0;
      wb_we         <= 1'b0;
      wb_exc        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op    <= '{is_load: in_is_load, funct3: in_funct3, rd: in_rd, off: in_addr[2:0]};
          wb_rd <= in_rd;
          if (!in_is_load && !in_is_store) begin
            wb_valid <= 1'b1;
            wb_data  <= in_alu_result;
            wb_we    <= (in_rd != 5'd0);
            wb_exc   <= 1'b0;
            state    <= WB;
          end else if (in_misal) begin
            wb_valid <= 1'b1;
            wb_data  <= XLEN'(in_addr);
            wb_we    <= 1'b0;
            wb_exc   <= 1'b1;
            state    <= WB;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_addr  <= {in_addr[ADDR_W-1:3], 3'b000};
            mem_req_we    <= in_is_store;
            mem_req_wstrb <= in_is_store ? (in_strb << in_addr[2:0]) : 8'hFF;
            mem_req_wdata <= in_is_store ? in_wdata : '0;
            wb_exc        <= 1'b0;
            state         <= REQ;
          end
        end
        REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          if (op.is_load) begin
            state <= WAIT;
          end else begin
            wb_valid <= 1'b1;
            wb_data  <= '0;
            wb_we    <= 1'b0;
            state    <= WB;
          end
        end
        WAIT: if (mem_resp_valid) begin
          wb_valid <= 1'b1;
          wb_data  <= ld_val;
          wb_we    <= (op.rd != 5'd0);
          state    <= WB;
        end
        WB: if (wb_ready) begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed vector bench for mem_stage: table of single instructions plus
// hand-written backpressure and reset-during-WAIT sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  in_kind;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [63:0] in_addr, in_store_data, in_alu_result;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic [63:0] mem_resp_data;
  logic        wb_valid, wb_ready, wb_we, wb_exc;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(64), .XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_funct3(in_funct3), .in_rd(in_rd), .in_addr(in_addr),
    .in_store_data(in_store_data), .in_alu_result(in_alu_result),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_we(wb_we), .wb_exc(wb_exc)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [63:0] addr, sdata, alu, resp;
    logic        req;
    logic [7:0]  wstrb;
    logic [63:0] wdata, wbdata;
    logic        chkd, wbwe, exc;
    int          lat;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mkv(logic [1:0] kind, logic [2:0] f3, logic [4:0] rd,
                               logic [63:0] addr, logic [63:0] sdata, logic [63:0] alu,
                               logic [63:0] resp, logic req, logic [7:0] wstrb,
                               logic [63:0] wdata, logic [63:0] wbdata, logic chkd,
                               logic wbwe, logic exc, int lat);
    vec_t v;
    v.kind = kind; v.f3 = f3; v.rd = rd; v.addr = addr; v.sdata = sdata;
    v.alu = alu; v.resp = resp; v.req = req; v.wstrb = wstrb; v.wdata = wdata;
    v.wbdata = wbdata; v.chkd = chkd; v.wbwe = wbwe; v.exc = exc; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    bit req_seen = 0, resp_given = 0, done = 0;
    @(negedge clk);
    chk($sformatf("v%0d in_ready idle", idx), in_ready, 1);
    in_valid = 1; in_kind = v.kind; in_funct3 = v.f3; in_rd = v.rd;
    in_addr = v.addr; in_store_data = v.sdata; in_alu_result = v.alu;
    mem_req_ready = 1; wb_ready = 1;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      mem_resp_valid = 0;
      if (wb_valid) begin
        chk($sformatf("v%0d latency", idx), 64'(c + 1), 64'(v.lat));
        chk($sformatf("v%0d wb_rd", idx), 64'(wb_rd), 64'(v.rd));
        chk($sformatf("v%0d wb_we", idx), 64'(wb_we), 64'(v.wbwe));
        chk($sformatf("v%0d wb_exc", idx), 64'(wb_exc), 64'(v.exc));
        if (v.chkd) chk($sformatf("v%0d wb_data", idx), wb_data, v.wbdata);
        done = 1;
      end else if (mem_req_valid) begin
        req_seen = 1;
        chk($sformatf("v%0d req_addr", idx), mem_req_addr, v.addr & ~64'h7);
        chk($sformatf("v%0d req_we", idx), 64'(mem_req_we), 64'(v.kind == 2'd2));
        chk($sformatf("v%0d req_wstrb", idx), 64'(mem_req_wstrb), 64'(v.wstrb));
        if (v.kind == 2'd2) chk($sformatf("v%0d req_wdata", idx), mem_req_wdata, v.wdata);
      end else if (req_seen && v.kind == 2'd1 && !resp_given) begin
        mem_resp_valid = 1; mem_resp_data = v.resp; resp_given = 1;
      end
      if (!done) @(negedge clk);
    end
    mem_resp_valid = 0;
    chk($sformatf("v%0d wb seen before timeout", idx), 64'(done), 1);
    chk($sformatf("v%0d bus request issued", idx), 64'(req_seen), 64'(v.req));
  endtask

  initial begin
    vecs[0]  = mkv(0, 0, 5, 0, 0, 64'h1234, 0, 0, 0, 0, 64'h1234, 1, 1, 0, 1);
    vecs[1]  = mkv(0, 0, 0, 0, 0, 64'h99, 0, 0, 0, 0, 64'h99, 1, 0, 0, 1);
    vecs[2]  = mkv(3, 2, 7, 64'h1001, 0, 64'h55, 0, 0, 0, 0, 64'h55, 1, 1, 0, 1);
    vecs[3]  = mkv(1, 0, 10, 64'h1003, 0, 0, 64'h80FF0000, 1, 8'hFF, 0, 64'hFFFFFFFFFFFFFF80, 1, 1, 0, 3);
    vecs[4]  = mkv(1, 4, 10, 64'h1003, 0, 0, 64'h80FF0000, 1, 8'hFF, 0, 64'h80, 1, 1, 0, 3);
    vecs[5]  = mkv(2, 1, 3, 64'h2006, 64'hABCD, 0, 0, 1, 8'hC0, 64'hABCD000000000000, 0, 0, 0, 0, 2);
    vecs[6]  = mkv(1, 2, 4, 64'h3002, 0, 0, 0, 0, 0, 0, 64'h3002, 1, 0, 1, 1);
    vecs[7]  = mkv(1, 3, 8, 64'h4008, 0, 0, 64'h8123456789ABCDEF, 1, 8'hFF, 0, 64'h8123456789ABCDEF, 1, 1, 0, 3);
    vecs[8]  = mkv(1, 1, 9, 64'h5002, 0, 0, 64'hF00D0000, 1, 8'hFF, 0, 64'hFFFFFFFFFFFFF00D, 1, 1, 0, 3);
    vecs[9]  = mkv(1, 5, 9, 64'h5002, 0, 0, 64'hF00D0000, 1, 8'hFF, 0, 64'hF00D, 1, 1, 0, 3);
    vecs[10] = mkv(1, 2, 11, 64'h6004, 0, 0, 64'h8765432100000000, 1, 8'hFF, 0, 64'hFFFFFFFF87654321, 1, 1, 0, 3);
    vecs[11] = mkv(1, 6, 11, 64'h6004, 0, 0, 64'h8765432100000000, 1, 8'hFF, 0, 64'h87654321, 1, 1, 0, 3);
    vecs[12] = mkv(2, 3, 1, 64'h7000, 64'h1122334455667788, 0, 0, 1, 8'hFF, 64'h1122334455667788, 0, 0, 0, 0, 2);
    vecs[13] = mkv(2, 0, 1, 64'h7005, 64'h12AA, 0, 0, 1, 8'h20, 64'h0012AA0000000000, 0, 0, 0, 0, 2);
    vecs[14] = mkv(1, 7, 12, 64'h8000, 0, 0, 64'hFEDCBA9876543210, 1, 8'hFF, 0, 64'hFEDCBA9876543210, 1, 1, 0, 3);
    vecs[15] = mkv(1, 7, 12, 64'h8004, 0, 0, 0, 0, 0, 0, 64'h8004, 1, 0, 1, 1);
    vecs[16] = mkv(2, 3, 2, 64'h9001, 64'h77, 0, 0, 0, 0, 0, 64'h9001, 1, 0, 1, 1);
    vecs[17] = mkv(1, 3, 0, 64'hA010, 0, 0, 64'h42, 1, 8'hFF, 0, 64'h42, 1, 0, 0, 3);
    vecs[18] = mkv(1, 1, 6, 64'h5001, 0, 0, 0, 0, 0, 0, 64'h5001, 1, 0, 1, 1);
    vecs[19] = mkv(2, 2, 6, 64'h5004, 64'hFFFFFFFFDEADBEEF, 0, 0, 1, 8'hF0, 64'hDEADBEEF00000000, 0, 0, 0, 0, 2);

    reset = 1; in_valid = 0; in_kind = 0; in_funct3 = 0; in_rd = 0; in_addr = 0;
    in_store_data = 0; in_alu_result = 0; mem_req_ready = 0; mem_resp_valid = 0;
    mem_resp_data = 0; wb_ready = 0;
    repeat (2) @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 1);
    chk("reset mem_req_valid", 64'(mem_req_valid), 0);
    chk("reset mem_req_wstrb", 64'(mem_req_wstrb), 0);
    chk("reset wb_valid", 64'(wb_valid), 0);
    chk("reset wb_data", wb_data, 0);
    reset = 0;

    for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

    // Backpressure on bus then on writeback; a stray in_valid in WB is ignored
    @(negedge clk);
    in_valid = 1; in_kind = 2; in_funct3 = 2; in_rd = 13; in_addr = 64'hA004;
    in_store_data = 64'hDEADBEEF; mem_req_ready = 0; wb_ready = 0;
    @(negedge clk);
    in_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("bp req_valid", 64'(mem_req_valid), 1);
      chk("bp req_addr", mem_req_addr, 64'hA000);
      chk("bp req_wstrb", 64'(mem_req_wstrb), 64'hF0);
      chk("bp req_wdata", mem_req_wdata, 64'hDEADBEEF00000000);
      chk("bp req_we", 64'(mem_req_we), 1);
      chk("bp in_ready req", 64'(in_ready), 0);
      @(negedge clk);
    end
    mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    in_valid = 1; in_kind = 0; in_rd = 20; in_alu_result = 64'h5A5A;
    for (int c = 0; c < 2; c++) begin
      chk("bp wb_valid", 64'(wb_valid), 1);
      chk("bp wb_rd", 64'(wb_rd), 13);
      chk("bp wb_we", 64'(wb_we), 0);
      chk("bp wb_exc", 64'(wb_exc), 0);
      chk("bp req dropped", 64'(mem_req_valid), 0);
      chk("bp in_ready wb", 64'(in_ready), 0);
      @(negedge clk);
    end
    wb_ready = 1;
    @(negedge clk);
    in_valid = 0;
    chk("bp wb_valid drops", 64'(wb_valid), 0);
    chk("bp in_ready back", 64'(in_ready), 1);
    @(negedge clk);
    chk("bp no bypassed op", 64'(wb_valid), 0);

    // Reset while waiting on a load response; the late response is dropped
    in_valid = 1; in_kind = 1; in_funct3 = 3; in_rd = 14; in_addr = 64'hB000;
    mem_req_ready = 1;
    @(negedge clk);
    in_valid = 0;
    chk("rst req_valid", 64'(mem_req_valid), 1);
    @(negedge clk);
    chk("rst in WAIT", 64'(mem_req_valid | wb_valid | in_ready), 0);
    reset = 1;
    @(negedge clk);
    reset = 0; mem_resp_valid = 1; mem_resp_data = 64'h1111;
    @(negedge clk);
    mem_resp_valid = 0;
    for (int c = 0; c < 3; c++) begin
      chk("rst wb_valid", 64'(wb_valid), 0);
      chk("rst in_ready", 64'(in_ready), 1);
      chk("rst req_addr", mem_req_addr, 0);
      chk("rst wb_data", wb_data, 0);
      chk("rst wb_rd", 64'(wb_rd), 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
